// File: rtl/time_set_ctrl_pkg.sv
// Shared types and helpers for the time/alarm setting controller.
// Timestamps are seconds-of-day (0..86399) and fit in 17 bits.
package time_set_ctrl_pkg;

  localparam logic [16:0] MIN_TICK  = 17'd60;
  localparam logic [16:0] HOUR_TICK = 17'd3600;

  localparam int unsigned HOLD_TICKS_DEF    = 4;
  localparam int unsigned REPEAT_TICKS_DEF  = 2;
  localparam int unsigned TIMEOUT_TICKS_DEF = 60;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_T_HOUR = 3'd1,
    ST_T_MIN  = 3'd2,
    ST_T_SEC  = 3'd3,
    ST_A_HOUR = 3'd4,
    ST_A_MIN  = 3'd5
  } state_e;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  function automatic hms_t unpack_ts(input logic [16:0] ts);
    hms_t t;
    t.h = 5'(ts / HOUR_TICK);
    t.m = 6'((ts % HOUR_TICK) / MIN_TICK);
    t.s = 6'(ts % MIN_TICK);
    return t;
  endfunction

  function automatic logic [16:0] pack_hms(input hms_t t);
    return 17'(t.h) * HOUR_TICK + 17'(t.m) * MIN_TICK + 17'(t.s);
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_pulse.sv
// Button level to 1-cycle pulse, registered the edge after a 0->1 sample; optional auto-repeat.
// Latency: pulse visible 1 posedge after the rising sample; no backpressure.
module btn_pulse #(
  parameter int unsigned HOLD_TICKS   = 4,
  parameter int unsigned REPEAT_TICKS = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  input  logic repeat_en,
  output logic pulse
);

  localparam int unsigned CW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam logic [CW-1:0] RPT_AT = CW'(HOLD_TICKS + REPEAT_TICKS);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_TICKS);

  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts held cycles since the press pulse; reloading to HOLD makes later repeats REPEAT apart
  always_comb begin
    level_d = level;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (!level) begin
      cnt_d = '0;
    end else if (!level_q) begin
      pulse_d = 1'b1;
      cnt_d   = '0;
    end else if (repeat_en) begin
      if (cnt_q + CW'(1) == RPT_AT) begin
        pulse_d = 1'b1;
        cnt_d   = RELOAD;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven edit FSM for setting the running time and the alarm time.
// Latency: button press to output change is 2 posedges; no backpressure.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_TICKS    = HOLD_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS  = REPEAT_TICKS_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_alarm,
  input  logic [16:0] counter_state,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_TICKS - 1);

  logic mode_p, inc_p, alarm_p;

  btn_pulse #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_mode (
    .clock(clock), .reset_n(reset_n), .level(btn_mode), .repeat_en(1'b0), .pulse(mode_p)
  );
  btn_pulse #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_inc (
    .clock(clock), .reset_n(reset_n), .level(btn_inc), .repeat_en(1'b1), .pulse(inc_p)
  );
  btn_pulse #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_alarm (
    .clock(clock), .reset_n(reset_n), .level(btn_alarm), .repeat_en(1'b0), .pulse(alarm_p)
  );

  state_e        state_q, state_d;
  hms_t          edit_q, edit_d;
  logic [16:0]   alarm_time_q, alarm_time_d;
  logic          alarm_en_q, alarm_en_d;
  logic [TW-1:0] idle_q, idle_d;

  // Priority mode > inc > alarm; idle time only accrues when no pulse arrives
  always_comb begin
    state_d      = state_q;
    edit_d       = edit_q;
    alarm_time_d = alarm_time_q;
    alarm_en_d   = alarm_en_q;
    idle_d       = '0;
    if (mode_p) begin
      unique case (state_q)
        ST_RUN: begin
          state_d = ST_T_HOUR;
          edit_d  = unpack_ts(counter_state);
        end
        ST_T_HOUR: state_d = ST_T_MIN;
        ST_T_MIN:  state_d = ST_T_SEC;
        ST_T_SEC: begin
          state_d = ST_A_HOUR;
          edit_d  = unpack_ts(alarm_time_q);
        end
        ST_A_HOUR: state_d = ST_A_MIN;
        ST_A_MIN: begin
          state_d      = ST_RUN;
          alarm_time_d = pack_hms('{h: edit_q.h, m: edit_q.m, s: 6'd0});
        end
        default: state_d = ST_RUN;
      endcase
    end else if (inc_p) begin
      unique case (state_q)
        ST_T_HOUR, ST_A_HOUR: edit_d.h = (edit_q.h >= 5'd23) ? 5'd0 : edit_q.h + 5'd1;
        ST_T_MIN, ST_A_MIN:   edit_d.m = (edit_q.m >= 6'd59) ? 6'd0 : edit_q.m + 6'd1;
        ST_T_SEC:             edit_d.s = (edit_q.s >= 6'd59) ? 6'd0 : edit_q.s + 6'd1;
        default: ;
      endcase
    end else if (alarm_p) begin
      if (state_q == ST_RUN) alarm_en_d = ~alarm_en_q;
    end else if (state_q != ST_RUN) begin
      if (idle_q == IDLE_LAST) state_d = ST_RUN;
      else                     idle_d  = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      edit_q       <= '0;
      alarm_time_q <= '0;
      alarm_en_q   <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      alarm_time_q <= alarm_time_d;
      alarm_en_q   <= alarm_en_d;
      idle_q       <= idle_d;
    end
  end

  // Flags decode from state so they move on the transition edge and drop with reset
  assign set_flag   = (state_q == ST_T_HOUR) || (state_q == ST_T_MIN) || (state_q == ST_T_SEC);
  assign alarm_flag = alarm_en_q && (state_q != ST_A_HOUR) && (state_q != ST_A_MIN);
  assign set_time   = pack_hms(edit_q);
  assign alarm_time = alarm_time_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: reset, vector table, hand-written corner sequences, then random
// stimulus against a seconds/fields reference model.
module tb_time_set_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int TMO  = 60;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        btn_mode, btn_inc, btn_alarm;
  logic [16:0] counter_state;
  logic        set_flag, alarm_flag;
  logic [16:0] set_time, alarm_time;

  always #5 clock = ~clock;

  time_set_ctrl #(.HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .TIMEOUT_TICKS(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_alarm(btn_alarm), .counter_state(counter_state), .set_flag(set_flag),
    .set_time(set_time), .alarm_flag(alarm_flag), .alarm_time(alarm_time)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=RUN 1..3=time h/m/s 4..5=alarm h/m; fields held as plain ints
  int m_st, m_h, m_m, m_s, m_atime, m_aen, m_idle;
  int m_k[3];
  int m_p[3];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_atime = 0; m_aen = 0; m_idle = 0;
    for (int b = 0; b < 3; b++) begin m_k[b] = 0; m_p[b] = 0; end
  endtask

  task automatic model_edge(input logic lm, input logic li, input logic la, input int cs);
    int pm, pi, pa;
    int lv[3];
    pm = m_p[0]; pi = m_p[1]; pa = m_p[2];
    if (pm != 0) begin
      m_idle = 0;
      case (m_st)
        0: begin m_st = 1; m_h = cs / 3600; m_m = (cs % 3600) / 60; m_s = cs % 60; end
        3: begin m_st = 4; m_h = m_atime / 3600; m_m = (m_atime % 3600) / 60; m_s = m_atime % 60; end
        5: begin m_st = 0; m_atime = m_h * 3600 + m_m * 60; end
        default: m_st = m_st + 1;
      endcase
    end else if (pi != 0) begin
      m_idle = 0;
      if (m_st == 1 || m_st == 4) m_h = (m_h + 1) % 24;
      if (m_st == 2 || m_st == 5) m_m = (m_m + 1) % 60;
      if (m_st == 3)              m_s = (m_s + 1) % 60;
    end else if (pa != 0) begin
      m_idle = 0;
      if (m_st == 0) m_aen = 1 - m_aen;
    end else if (m_st != 0) begin
      m_idle++;
      if (m_idle == TMO) begin m_st = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
    lv[0] = int'(lm); lv[1] = int'(li); lv[2] = int'(la);
    for (int b = 0; b < 3; b++) begin
      m_k[b] = (lv[b] != 0) ? m_k[b] + 1 : 0;
      m_p[b] = (m_k[b] == 1 ||
               (b == 1 && m_k[b] >= HOLD + REP + 1 && (m_k[b] - 1 - HOLD) % REP == 0)) ? 1 : 0;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_set_flag"},   int'(set_flag),   (m_st >= 1 && m_st <= 3) ? 1 : 0);
    chk({tag, "_set_time"},   int'(set_time),   m_h * 3600 + m_m * 60 + m_s);
    chk({tag, "_alarm_flag"}, int'(alarm_flag), (m_aen != 0 && m_st < 4) ? 1 : 0);
    chk({tag, "_alarm_time"}, int'(alarm_time), m_atime);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge(btn_mode, btn_inc, btn_alarm, int'(counter_state));
    #1;
  endtask

  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1;
    if (which == 1) btn_inc = 1'b1;
    if (which == 2) btn_alarm = 1'b1;
    cyc();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
    cyc();
  endtask

  typedef struct {
    int m; int i; int a;
    int sf; int st; int af; int at;
  } vec_t;

  vec_t tv[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1, 0, 0, 0, 0,     0, 0};
    tv[1]  = '{0, 0, 0, 1, 34953, 0, 0};
    tv[2]  = '{0, 1, 0, 1, 34953, 0, 0};
    tv[3]  = '{0, 0, 0, 1, 38553, 0, 0};
    tv[4]  = '{1, 0, 0, 1, 38553, 0, 0};
    tv[5]  = '{0, 0, 0, 1, 38553, 0, 0};
    tv[6]  = '{0, 1, 0, 1, 38553, 0, 0};
    tv[7]  = '{0, 0, 0, 1, 38613, 0, 0};
    tv[8]  = '{0, 1, 0, 1, 38613, 0, 0};
    tv[9]  = '{0, 0, 0, 1, 38673, 0, 0};
    tv[10] = '{1, 0, 0, 1, 38673, 0, 0};
    tv[11] = '{0, 0, 0, 1, 38673, 0, 0};
    tv[12] = '{1, 0, 0, 1, 38673, 0, 0};
    tv[13] = '{0, 0, 0, 0, 0,     0, 0};

    // Reset with mode held: nothing may move
    reset_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
    counter_state = 17'd34953;
    model_reset();
    repeat (2) @(posedge clock);
    #1 btn_mode = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_set_flag", int'(set_flag), 0);
    chk("rst_set_time", int'(set_time), 0);
    chk("rst_alarm_flag", int'(alarm_flag), 0);
    chk("rst_alarm_time", int'(alarm_time), 0);
    btn_mode = 1'b0;
    reset_n  = 1'b1;
    cyc(); cyc();
    chk("post_rst_set_flag", int'(set_flag), 0);
    chk("post_rst_set_time", int'(set_time), 0);

    for (int r = 0; r < 14; r++) begin
      btn_mode = (tv[r].m != 0); btn_inc = (tv[r].i != 0); btn_alarm = (tv[r].a != 0);
      cyc();
      chk($sformatf("vec%0d_set_flag", r),   int'(set_flag),   tv[r].sf);
      chk($sformatf("vec%0d_set_time", r),   int'(set_time),   tv[r].st);
      chk($sformatf("vec%0d_alarm_flag", r), int'(alarm_flag), tv[r].af);
      chk($sformatf("vec%0d_alarm_time", r), int'(alarm_time), tv[r].at);
    end

    // Alarm edit 14:08 and commit
    repeat (14) press(1);
    chk("alarm_hour_edit", int'(set_time), 50400);
    chk("alarm_flag_in_A", int'(alarm_flag), 0);
    press(0);
    repeat (8) press(1);
    chk("alarm_min_edit", int'(set_time), 50880);
    press(0);
    chk("alarm_commit", int'(alarm_time), 50880);
    chk("alarm_flag_back", int'(alarm_flag), 0);
    chk("set_flag_run", int'(set_flag), 0);

    // Alarm toggle in RUN: one edge to register the pulse, one to act
    btn_alarm = 1'b1; cyc();
    chk("alarm_toggle_early", int'(alarm_flag), 0);
    btn_alarm = 1'b0; cyc();
    chk("alarm_toggle", int'(alarm_flag), 1);

    // Hour wrap from 23:59:59, alarm ignored while editing
    counter_state = 17'd86399;
    press(0);
    chk("t_hour_load", int'(set_time), 86399);
    chk("t_hour_set_flag", int'(set_flag), 1);
    press(2);
    chk("alarm_ignored_T", int'(alarm_flag), 1);
    press(1);
    chk("hour_wrap", int'(set_time), 3599);
    press(0);

    // Held inc in T_MIN for 12 cycles: four increments, 59 wraps to 0 first
    btn_inc = 1'b1;
    repeat (12) cyc();
    btn_inc = 1'b0;
    cyc(); cyc();
    chk("hold_repeat", int'(set_time), 239);

    // Simultaneous mode+inc: advance to T_SEC without incrementing
    btn_mode = 1'b1; btn_inc = 1'b1; cyc();
    btn_mode = 1'b0; btn_inc = 1'b0; cyc();
    chk("mode_inc_same", int'(set_time), 239);
    press(1);
    chk("sec_wrap", int'(set_time), 180);

    // Idle timeout in A_MIN: no commit, flag restored
    press(0);
    chk("a_hour_flag", int'(alarm_flag), 0);
    chk("a_hour_load", int'(set_time), 50880);
    press(0);
    press(1);
    chk("a_min_inc", int'(set_time), 50940);
    repeat (TMO - 1) cyc();
    chk("pre_timeout_flag", int'(alarm_flag), 0);
    cyc();
    chk("timeout_flag", int'(alarm_flag), 1);
    chk("timeout_alarm_time", int'(alarm_time), 50880);
    chk("timeout_set_flag", int'(set_flag), 0);
    model_check("hand_end");

    // Asynchronous reset mid-edit
    press(0);
    chk("pre_async_set_flag", int'(set_flag), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_set_flag", int'(set_flag), 0);
    chk("async_alarm_time", int'(alarm_time), 0);
    chk("async_alarm_flag", int'(alarm_flag), 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc();
    model_check("after_async");

    // Random levels with periodic idle windows so timeouts occur
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 < 80) begin
        btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
        if ($urandom_range(0, 11) == 0) btn_alarm = ~btn_alarm;
      end
      counter_state = 17'($urandom_range(0, 86399));
      cyc();
      model_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
